// File: rtl/ws_sa_pkg.sv
// Shared constants and types for the 4x4 weight-stationary systolic array.
package ws_sa_pkg;

  localparam int unsigned ARRAY_DIM          = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned PSUM_WIDTH         = 2 * DEFAULT_DATA_WIDTH;
  localparam int unsigned CNT_WIDTH          = $clog2(ARRAY_DIM);

  typedef enum logic {
    StIdle,
    StLoad
  } load_st_e;

endpackage

// File: rtl/ws_pe.sv
// Weight-stationary MAC processing element: holds w, registers f and p every cycle.
// WS_SA_SIGNED_EN selects two's-complement operands instead of unsigned.
module ws_pe
  import ws_sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    w_we_i,
  input  logic [DATA_WIDTH-1:0]   w_i,
  input  logic [DATA_WIDTH-1:0]   f_i,
  input  logic [2*DATA_WIDTH-1:0] p_i,
  output logic [DATA_WIDTH-1:0]   f_o,
  output logic [2*DATA_WIDTH-1:0] p_o
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] w_q, f_q;
  logic [PW-1:0]         p_q, prod;

`ifdef WS_SA_SIGNED_EN
  logic signed [PW-1:0] f_ext, w_ext;
  assign f_ext = PW'($signed(f_i));
  assign w_ext = PW'($signed(w_q));
  assign prod  = f_ext * w_ext;
`else
  assign prod = PW'(f_i) * PW'(w_q);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_q <= '0;
      f_q <= '0;
      p_q <= '0;
    end else begin
      if (w_we_i) begin
        w_q <= w_i;
      end
      f_q <= f_i;
      p_q <= p_i + prod;
    end
  end

  assign f_o = f_q;
  assign p_o = p_q;

endmodule

// File: rtl/ws_systolic_array_4x4.sv
// 4x4 weight-stationary systolic array: 16 ws_pe tiles plus the row-by-row weight loader.
// WS_SA_SIGNED_EN (passed to ws_pe) enables signed arithmetic.
module ws_systolic_array_4x4
  import ws_sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_start,
  input  logic [DATA_WIDTH-1:0]   i_w_col_1,
  input  logic [DATA_WIDTH-1:0]   i_w_col_2,
  input  logic [DATA_WIDTH-1:0]   i_w_col_3,
  input  logic [DATA_WIDTH-1:0]   i_w_col_4,
  input  logic [DATA_WIDTH-1:0]   i_f_row_1,
  input  logic [DATA_WIDTH-1:0]   i_f_row_2,
  input  logic [DATA_WIDTH-1:0]   i_f_row_3,
  input  logic [DATA_WIDTH-1:0]   i_f_row_4,
  output logic [2*DATA_WIDTH-1:0] o_p_col_1,
  output logic [2*DATA_WIDTH-1:0] o_p_col_2,
  output logic [2*DATA_WIDTH-1:0] o_p_col_3,
  output logic [2*DATA_WIDTH-1:0] o_p_col_4
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  load_st_e               st_q, st_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ARRAY_DIM-1:0]   row_we;

  logic [DATA_WIDTH-1:0] w_col [ARRAY_DIM];
  logic [DATA_WIDTH-1:0] f_row [ARRAY_DIM];
  logic [DATA_WIDTH-1:0] f_in  [ARRAY_DIM][ARRAY_DIM];
  logic [DATA_WIDTH-1:0] f_out [ARRAY_DIM][ARRAY_DIM];
  logic [PW-1:0]         p_in  [ARRAY_DIM][ARRAY_DIM];
  logic [PW-1:0]         p_out [ARRAY_DIM][ARRAY_DIM];

  assign w_col[0] = i_w_col_1;
  assign w_col[1] = i_w_col_2;
  assign w_col[2] = i_w_col_3;
  assign w_col[3] = i_w_col_4;
  assign f_row[0] = i_f_row_1;
  assign f_row[1] = i_f_row_2;
  assign f_row[2] = i_f_row_3;
  assign f_row[3] = i_f_row_4;

  always_ff @(posedge clk) begin
    if (rstn) begin
      st_q  <= StIdle;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // A start pulse always wins: it rewinds to row 1 without writing on that edge.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    row_we = '0;
    if (i_start) begin
      st_d  = StLoad;
      cnt_d = '0;
    end else if (st_q == StLoad) begin
      row_we[cnt_q] = 1'b1;
      cnt_d         = cnt_q + 1'b1;
      if (cnt_q == CNT_WIDTH'(ARRAY_DIM - 1)) begin
        st_d = StIdle;
      end
    end
  end

  for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_row
    for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_col
      if (c == 0) begin : g_f_edge
        assign f_in[r][c] = f_row[r];
      end else begin : g_f_chain
        assign f_in[r][c] = f_out[r][c-1];
      end
      if (r == 0) begin : g_p_edge
        assign p_in[r][c] = '0;
      end else begin : g_p_chain
        assign p_in[r][c] = p_out[r-1][c];
      end

      ws_pe #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_pe (
        .clk_i (clk),
        .rst_i (rstn),
        .w_we_i(row_we[r]),
        .w_i   (w_col[c]),
        .f_i   (f_in[r][c]),
        .p_i   (p_in[r][c]),
        .f_o   (f_out[r][c]),
        .p_o   (p_out[r][c])
      );
    end
  end

  // Features leaving the right edge have no consumer.
  logic unused_f_edge;
  assign unused_f_edge = ^{f_out[0][ARRAY_DIM-1], f_out[1][ARRAY_DIM-1],
                           f_out[2][ARRAY_DIM-1], f_out[3][ARRAY_DIM-1]};

  assign o_p_col_1 = p_out[ARRAY_DIM-1][0];
  assign o_p_col_2 = p_out[ARRAY_DIM-1][1];
  assign o_p_col_3 = p_out[ARRAY_DIM-1][2];
  assign o_p_col_4 = p_out[ARRAY_DIM-1][3];

endmodule

// File: tb/tb_ws_systolic_array_4x4.sv
// Directed bench for ws_systolic_array_4x4 with a due-cycle scoreboard on the column outputs.
module tb_ws_systolic_array_4x4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_start;
  logic [7:0]  w1, w2, w3, w4;
  logic [7:0]  f1, f2, f3, f4;
  logic [15:0] o1, o2, o3, o4;

  ws_systolic_array_4x4 #(
    .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_start  (i_start),
    .i_w_col_1(w1),
    .i_w_col_2(w2),
    .i_w_col_3(w3),
    .i_w_col_4(w4),
    .i_f_row_1(f1),
    .i_f_row_2(f2),
    .i_f_row_3(f3),
    .i_f_row_4(f4),
    .o_p_col_1(o1),
    .o_p_col_2(o2),
    .o_p_col_3(o3),
    .o_p_col_4(o4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          col;
    logic [15:0] exp;
    string       tag;
  } sb_t;

  sb_t         sb[$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [7:0]  wm [4][4];
  logic [7:0]  el [64][4];
  int          n_el = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [15:0] outc(input int c);
    case (c)
      0:       return o1;
      1:       return o2;
      2:       return o3;
      default: return o4;
    endcase
  endfunction

  function automatic logic [7:0] ev(input int k, input int r);
    return (k >= 0 && k < n_el) ? el[k][r] : 8'd0;
  endfunction

  function automatic logic [15:0] ext(input logic [7:0] x);
`ifdef WS_SA_SIGNED_EN
    return {{8{x[7]}}, x};
`else
    return {8'd0, x};
`endif
  endfunction

  function automatic logic [15:0] mac_model(input int k, input int c);
    logic [15:0] acc = 16'd0;
    for (int r = 0; r < 4; r++) acc = 16'(acc + ext(ev(k, r)) * ext(wm[r][c]));
    return acc;
  endfunction

  // Scoreboard drain: compare every entry whose due cycle is now.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk($sformatf("%s c%0d", sb[i].tag, sb[i].col + 1), outc(sb[i].col), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wrow(input int r);
    w1 = wm[r][0]; w2 = wm[r][1]; w3 = wm[r][2]; w4 = wm[r][3];
  endtask

  task automatic set_w_all(input logic [7:0] v);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wm[r][c] = v;
  endtask

  task automatic do_load();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      drive_wrow(r);
      tick();
    end
    {w1, w2, w3, w4} = '0;
  endtask

  // Skewed stream of n elements; fixed >= 0 overrides the model for real elements.
  task automatic stream(input int n, input string tag, input int fixed);
    int          t0;
    logic [15:0] e;
    n_el = n;
    t0   = cyc;
    for (int j = 0; j < n + 7; j++) begin
      f1 = ev(j, 0); f2 = ev(j - 1, 1); f3 = ev(j - 2, 2); f4 = ev(j - 3, 3);
      if (j < n + 3) begin
        for (int c = 0; c < 4; c++) begin
          e = (fixed >= 0 && j < n) ? 16'(fixed) : mac_model(j, c);
          sb.push_back('{t0 + j + 4 + c, c, e, $sformatf("%s k%0d", tag, j)});
        end
      end
      tick();
    end
    {f1, f2, f3, f4} = '0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      chk_cnt++;
      $error("FAIL %s drain pending=%0d required=0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk);
    for (int c = 0; c < 4; c++) chk($sformatf("%s c%0d", tag, c + 1), outc(c), 16'd0);
  endtask

  task automatic rand_in();
    {w1, w2, w3, w4} = $urandom;
    {f1, f2, f3, f4} = $urandom;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rstn    = 1'b1;
    i_start = 1'b0;
    rand_in();
    for (int i = 0; i < 5; i++) begin
      i_start = 1'($urandom_range(0, 1));
      rand_in();
      tick();
      chk_zero("reset");
    end
    rstn    = 1'b0;
    i_start = 1'b0;
    {w1, w2, w3, w4, f1, f2, f3, f4} = '0;
    tick();
    chk_zero("post_reset");

    // Identity weights, row-1 ramp
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wm[r][c] = (r == c) ? 8'd1 : 8'd0;
    do_load();
    for (int k = 0; k < 16; k++) for (int r = 0; r < 4; r++) el[k][r] = (r == 0) ? 8'(k + 1) : 8'd0;
    stream(16, "ident", -1);
    drain("ident");

    // All-ones weights, row r constant r
    set_w_all(8'd1);
    do_load();
    for (int k = 0; k < 8; k++) for (int r = 0; r < 4; r++) el[k][r] = 8'(r + 1);
    stream(8, "ones", 10);
    drain("ones");

    // Wrap-around
    set_w_all(8'd255);
    do_load();
    for (int k = 0; k < 6; k++) for (int r = 0; r < 4; r++) el[k][r] = 8'd255;
`ifdef WS_SA_SIGNED_EN
    stream(6, "wrap", 4);
`else
    stream(6, "wrap", 63492);
`endif
    drain("wrap");

    // Reload with a restart mid-load: garbage rows must be overwritten
    set_w_all(8'd2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    {w1, w2, w3, w4} = 32'h37_37_37_37;
    tick();
    {w1, w2, w3, w4} = 32'h59_59_59_59;
    tick();
    i_start = 1'b1;
    {w1, w2, w3, w4} = 32'h7b_7b_7b_7b;
    tick();
    i_start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      drive_wrow(r);
      tick();
    end
    {w1, w2, w3, w4} = '0;
    for (int k = 0; k < 8; k++) for (int r = 0; r < 4; r++) el[k][r] = 8'(r + 1);
    stream(8, "reload", 20);
    drain("reload");

    // Reset mid-stream, with start held high during the reset edge
    for (int i = 0; i < 5; i++) begin
      {f1, f2, f3, f4} = $urandom;
      tick();
    end
    rstn    = 1'b1;
    i_start = 1'b1;
    tick();
    chk_zero("mid_reset");
    rstn    = 1'b0;
    i_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_in();
      tick();
      chk_zero("cleared_w");
    end
    {w1, w2, w3, w4, f1, f2, f3, f4} = '0;

    // Random full load + stream after recovery
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wm[r][c] = 8'($urandom);
    do_load();
    for (int k = 0; k < 12; k++) for (int r = 0; r < 4; r++) el[k][r] = 8'($urandom);
    stream(12, "random", -1);
    drain("random");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
